jt49_div_sched: RTL and testbench
=================================

Name: jt49_div_sched

Overview:
Time-shared period divider for all JT49 frequency generators: tone A/B/C, noise, envelope. One W-bit counter/comparator datapath is swept across NCH channel count registers once per core clock-enable. Per-channel enable pulses are emitted simultaneously at the end of each sweep. Sits between the register file and the tone/noise/envelope generators and replaces one dedicated divider per channel.

Parameters:
NCH, 5, number of channels served; channel 0 = first slot of each sweep.
W, 16, period and count width; narrower periods (12-bit tone, 5-bit noise) are zero-extended by the instantiating module.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
cen  in  1  core clock enable; one tick = one divide step for every channel
period  in  NCH*W  channel periods; channel i at bits [i*W +: W]
cen_div  out  NCH  per-channel one-clk divide pulse
busy  out  1  sweep in progress or sweep pending
overrun  out  1  sticky: a cen tick was lost (OVR feature only)
ovr_clr  in  1  clears overrun (OVR feature only)

Behaviour:
- Reset: cen_div=0, busy=0, overrun=0. State=IDLE, pending=0, idx=0. Every count register = 1. Reset has priority in every state; a sweep in progress is aborted and no pulses are emitted.
- FSM states: IDLE and SWEEP.
- IDLE: cen=1 -> SWEEP with idx=0. cen=0 -> stay in IDLE.
- SWEEP: one channel per clk, at idx. period[idx] is sampled in this slot only (no earlier snapshot).
  - period==0 -> count<=1, hit[idx]<=0.
  - count>=period -> count<=1, hit[idx]<=1. Uses >= so that a period reduced below the current count reloads at the next visit instead of wrapping.
  - Otherwise -> count<=count+1, hit[idx]<=0.
  - Count arithmetic is W bits; by construction count never exceeds the largest period seen, so no overflow.
- End of sweep: after slot idx=NCH-1, cen_div<=hit vector for exactly one clk; all other clks cen_div=0.
- Latency: cen sampled high at edge t from IDLE -> slots at edges t+1..t+NCH -> cen_div high during cycle after edge t+NCH+1.
- Next state after the last slot: if pending=1 -> clear pending and start a new sweep immediately (idx=0, no idle cycle); else -> IDLE.
- busy = (state==SWEEP) | pending.
- cen sampled in SWEEP: sets pending. If pending is already set, the tick is lost (see overrun).
- cen on the same edge as the last slot is treated as pending, so the next sweep starts back-to-back.
- Integration requirement: cen spacing must be at least NCH+1 clks; this guarantees no tick is lost.
- Division ratio for channel i with period P>0: one cen_div pulse every P cen ticks. The first pulse comes P ticks after reset.

Optional Feature:
Macro JT49_DIV_SCHED_OVR_EN.
- Defined:
  - overrun is set on a cen that arrives while pending=1 and the state is SWEEP.
  - overrun stays set until ovr_clr=1. Clear has priority over a simultaneous set.
  - Reset clears overrun.
- Not defined: overrun is tied 0, ovr_clr is ignored, and no detection logic is built. All other behaviour is identical in both builds.

Test Plan:
1. NCH=5, W=16, period ch0=3, ch1=1, others 0; cen every 8 clks for 12 ticks -> ch0 pulses on ticks 3,6,9,12. ch1 pulses on every tick. ch2-4 never pulse. Each pulse appears 6 clks after its cen.
2. ch0 period=10; after 5 ticks (count=6) write period=2 -> pulse on the very next tick, then every 2 ticks.
3. cen at clk 0 and clk 2 -> second sweep starts at clk 6 with no gap; busy stays high clks 1-10; two cen_div events at clks 6 and 11.
4. With JT49_DIV_SCHED_OVR_EN: cen at clks 0, 2, 3 -> overrun=1 from clk 4; ovr_clr at clk 20 -> overrun=0. Without the macro: overrun stays 0.
5. rst_n=0 for one clk at slot idx=2 of a sweep -> no cen_div pulse, busy=0, all counts reload to 1. Next ticks produce a ch0 (period=3) pulse on the 3rd tick after reset.
6. All periods = 0xFFFF, 65535 ticks -> single pulse on every channel at tick 65535. Counts wrap to 1 with no overflow.

Source files
------------

// File: rtl/jt49_div_sched.sv
// jt49_div_sched
//
// Time-shared period divider for the JT49 frequency generators (tone A/B/C,
// noise, envelope). One W-bit counter/comparator is swept across NCH
// per-channel count registers once per core clock-enable tick. All
// per-channel divide pulses are emitted together, one clk after the sweep
// ends.
//
// Build option: define JT49_DIV_SCHED_OVR_EN to build the sticky overrun
// detector. Without it, overrun is tied 0 and ovr_clr is ignored.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   cen          core clock enable; one tick = one divide step per channel
//   period       channel periods, channel i at [i*W +: W]; 0 = never pulse
//   cen_div      per-channel one-clk divide pulse
//   busy         sweep in progress or a sweep is pending
//   overrun      sticky flag: a cen tick was lost (OVR build only)
//   ovr_clr      clears overrun (OVR build only)
//   dbg_state_o  FSM state for debug (0 = IDLE, 1 = SWEEP)
//
// Handshake: cen is a single-cycle strobe with no back-pressure. A tick
// seen while sweeping is remembered in one pending slot; a second tick
// while that slot is full is lost.

module jt49_div_sched #(
  parameter int NCH = 5,
  parameter int W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  input  logic [NCH*W-1:0] period,
  output logic [NCH-1:0]   cen_div,
  output logic             busy,
  output logic             overrun,
  input  logic             ovr_clr,
  output logic             dbg_state_o
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t         state_q;
  logic           pending_q;
  logic [IW-1:0]  idx_q;
  logic [W-1:0]   cnt_q [NCH];
  logic [NCH-1:0] hit_q;
  logic           last_q;   // last slot was processed on the previous edge
  logic [NCH-1:0] cen_div_q;

  // Current slot: the period is read only while its channel is being served.
  logic [W-1:0] per_sel;
  logic [W-1:0] cnt_sel;
  logic [W-1:0] cnt_d;
  logic         hit_d;
  logic         lost;

  always_comb begin
    per_sel = period[idx_q*W +: W];
    cnt_sel = cnt_q[idx_q];
    cnt_d   = cnt_sel + 1'b1;
    hit_d   = 1'b0;
    if (per_sel == '0) begin
      cnt_d = W'(1);
    end else if (cnt_sel >= per_sel) begin
      // >= so a period lowered below the running count reloads at once.
      cnt_d = W'(1);
      hit_d = 1'b1;
    end
  end

  // A tick arriving with the pending slot already full is dropped.
  assign lost = (state_q == SWEEP) && cen && pending_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      idx_q     <= '0;
      hit_q     <= '0;
      last_q    <= 1'b0;
      cen_div_q <= '0;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= W'(1);
    end else begin
      last_q    <= 1'b0;
      cen_div_q <= last_q ? hit_q : '0;
      case (state_q)
        IDLE: begin
          if (cen) begin
            state_q <= SWEEP;
            idx_q   <= '0;
          end
        end
        SWEEP: begin
          cnt_q[idx_q] <= cnt_d;
          hit_q[idx_q] <= hit_d;
          if (idx_q == LAST_IDX) begin
            last_q <= 1'b1;
            idx_q  <= '0;
            // A pending tick, or a tick on this very edge, restarts at once.
            if (pending_q || cen) begin
              pending_q <= 1'b0;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            idx_q <= idx_q + 1'b1;
            if (cen) pending_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cen_div     = cen_div_q;
  assign busy        = (state_q == SWEEP) || pending_q;
  assign dbg_state_o = (state_q == SWEEP);

`ifdef JT49_DIV_SCHED_OVR_EN
  logic ovr_q;

  // Clear wins over a simultaneous set.
  always_ff @(posedge clk) begin
    if (!rst_n)       ovr_q <= 1'b0;
    else if (ovr_clr) ovr_q <= 1'b0;
    else if (lost)    ovr_q <= 1'b1;
  end

  assign overrun = ovr_q;
`else
  logic unused_ovr;
  assign unused_ovr = ovr_clr ^ lost;
  assign overrun    = 1'b0;
`endif

endmodule

// File: tb/tb_jt49_div_sched.sv
// Bench for jt49_div_sched: a table of per-tick periods and expected
// divide pulses, plus hand-written multi-cycle sequences (back-to-back
// sweeps, overrun, reset mid-sweep, large periods).

module tb_jt49_div_sched;

  localparam int NCH = 5;
  localparam int W   = 16;
`ifdef JT49_DIV_SCHED_OVR_EN
  localparam logic OVR = 1'b1;
`else
  localparam logic OVR = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cen = 1'b0;
  logic [NCH*W-1:0] period = '0;
  logic [NCH-1:0]   cen_div;
  logic             busy;
  logic             overrun;
  logic             ovr_clr = 1'b0;
  logic             dbg_state;

  always #5 clk = ~clk;

  jt49_div_sched #(.NCH(NCH), .W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cen         (cen),
    .period      (period),
    .cen_div     (cen_div),
    .busy        (busy),
    .overrun     (overrun),
    .ovr_clr     (ovr_clr),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [NCH-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NCH*W-1:0] mk(input logic [W-1:0] p0, p1, p2, p3, p4);
    return {p4, p3, p2, p1, p0};
  endfunction

  // ---------------- driver tasks ----------------
  // All tasks start and end #1 after a rising edge.
  task automatic do_reset();
    rst_n = 1'b0;
    cen = 1'b0;
    ovr_clr = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
  endtask

  // One cen tick; returns cen_div sampled after edge t+NCH+1. Ticks are
  // spaced 8 clks apart.
  task automatic do_tick(output logic [NCH-1:0] got);
    cen = 1'b1;
    @(posedge clk); #1;
    cen = 1'b0;
    repeat (NCH + 1) begin @(posedge clk); #1; end
    got = cen_div;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [NCH*W-1:0] per;
    logic [NCH-1:0]   exp;
  } vec_t;

  vec_t tbl[20];
  logic [NCH-1:0] got;
  logic [NCH-1:0] acc;

  initial begin
    // Ticks 1..12: ch0=3, ch1=1. Ticks 13..17: ch0=10 (count reaches 6).
    // Ticks 18..20: ch0 lowered to 2 -> immediate pulse, then every 2.
    for (int n = 1; n <= 12; n++) begin
      tbl[n-1].per = mk(16'd3, 16'd1, 16'd0, 16'd0, 16'd0);
      tbl[n-1].exp = {3'b000, 1'b1, (n % 3 == 0)};
    end
    for (int n = 13; n <= 17; n++) begin
      tbl[n-1].per = mk(16'd10, 16'd0, 16'd0, 16'd0, 16'd0);
      tbl[n-1].exp = '0;
    end
    for (int n = 18; n <= 20; n++) begin
      tbl[n-1].per = mk(16'd2, 16'd0, 16'd0, 16'd0, 16'd0);
      tbl[n-1].exp = (n == 19) ? 5'b00000 : 5'b00001;
    end

    @(posedge clk); #1;
    do_reset();
    chk("reset_cen_div", 32'(cen_div), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_overrun", 32'(overrun), 0);
    chk("reset_state", 32'(dbg_state), 0);

    // ---- table-driven divide vectors ----
    foreach (tbl[i]) exp_q.push_back(tbl[i].exp);
    foreach (tbl[i]) begin
      period = tbl[i].per;
      do_tick(got);
      chk($sformatf("tick%0d_cen_div", i + 1), 32'(got), 32'(exp_q.pop_front()));
      chk($sformatf("tick%0d_idle", i + 1), 32'(busy), 0);
    end

    // ---- back-to-back sweeps: cen at edges 0 and 2 ----
    period = mk(16'd0, 16'd1, 16'd0, 16'd0, 16'd0);
    cen = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      @(posedge clk); #1;
      cen = (k == 1);
      chk($sformatf("b2b_busy_k%0d", k), 32'(busy), (k <= 9) ? 1 : 0);
      chk($sformatf("b2b_cen_div_k%0d", k), 32'(cen_div),
          (k == 6 || k == 11) ? 32'h2 : 32'h0);
    end
    repeat (3) begin @(posedge clk); #1; end

    // ---- overrun: cen at edges 0, 2, 3; clear sampled at edge 20 ----
    cen = 1'b1;
    for (int k = 0; k <= 24; k++) begin
      @(posedge clk); #1;
      cen = (k == 1 || k == 2);
      ovr_clr = (k == 19);
      if (k == 2)  chk("ovr_not_yet", 32'(overrun), 0);
      if (k == 4)  chk("ovr_set", 32'(overrun), 32'(OVR));
      if (k == 19) chk("ovr_sticky", 32'(overrun), 32'(OVR));
      if (k == 20) chk("ovr_cleared", 32'(overrun), 0);
    end
    chk("ovr_idle_after", 32'(busy), 0);

    // ---- reset during slot idx=2 ----
    do_reset();
    period = mk(16'd3, 16'd0, 16'd0, 16'd0, 16'd0);
    do_tick(got);
    chk("rst_pre_tick", 32'(got), 0);
    cen = 1'b1;
    @(posedge clk); #1;   // edge t
    cen = 1'b0;
    @(posedge clk); #1;   // slot 0
    @(posedge clk); #1;   // slot 1
    rst_n = 1'b0;
    @(posedge clk); #1;   // slot 2 edge sees reset
    rst_n = 1'b1;
    chk("rst_mid_busy", 32'(busy), 0);
    acc = '0;
    repeat (5) begin @(posedge clk); #1; acc |= cen_div; end
    chk("rst_mid_no_pulse", 32'(acc), 0);
    for (int n = 1; n <= 3; n++) begin
      do_tick(got);
      chk($sformatf("rst_after_tick%0d", n), 32'(got), (n == 3) ? 1 : 0);
    end

    // ---- large periods: no pulse, then a lowered period reloads ----
    do_reset();
    period = mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    acc = '0;
    for (int n = 0; n < 1000; n++) begin
      do_tick(got);
      acc |= got;
    end
    chk("big_no_pulse", 32'(acc), 0);
    period = mk(16'd50, 16'd50, 16'd50, 16'd50, 16'd50);
    do_tick(got);
    chk("big_lowered_pulse", 32'(got), 32'h1F);
    do_tick(got);
    chk("big_after_reload", 32'(got), 0);

    // ---- final report ----
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
